// File: rtl/chacha_xor_stream.sv
// chacha_xor_stream: XORs 512-bit ChaCha keystream blocks, one DATA_W lane per beat, onto a
// valid/ready stream, with an optional one-block prefetch slot to hide keystream latency.
module chacha_xor_stream #(
    parameter int DATA_W   = 128,
    parameter bit PREFETCH = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   in_data,
    input  logic [DATA_W/8-1:0] in_keep,
    input  logic                in_last,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   out_data,
    output logic [DATA_W/8-1:0] out_keep,
    output logic                out_last,
    output logic                ks_req,
    input  logic                ks_valid,
    input  logic [511:0]        ks_data,
    output logic                busy,
    output logic [31:0]         blk_cnt
);
    localparam int LANES = 512 / DATA_W;
    localparam int KW = DATA_W / 8;
    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [LW-1:0] LANE_MAX = LW'(LANES - 1);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_RUN, S_DRAIN} state_t;

    state_t        state_q, state_d;
    logic [511:0]  cur_q, cur_d, nxt_q, nxt_d;
    logic          cur_full_q, cur_full_d, nxt_full_q, nxt_full_d;
    logic [LW-1:0] lane_q, lane_d;
    logic          ks_req_q, ks_req_d;
    logic          out_valid_q, out_valid_d, out_last_q, out_last_d;
    logic [DATA_W-1:0] out_data_q, out_data_d, lane_sel, keep_mask;
    logic [KW-1:0] out_keep_q, out_keep_d;
    logic [31:0]   blk_cnt_q, blk_cnt_d;
    logic          accept, ks_hit, slot_free, active, end_msg;

    assign lane_sel  = cur_q[int'(lane_q)*DATA_W +: DATA_W];
    assign in_ready  = (state_q == S_RUN) && cur_full_q && (!out_valid_q || out_ready);
    assign accept    = in_valid && in_ready;
    assign end_msg   = accept && in_last;
    // A pulse only counts against a request we actually have in flight.
    assign ks_hit    = ks_valid && ks_req_q;
    assign active    = (state_q == S_FETCH) || (state_q == S_RUN);
    assign slot_free = PREFETCH ? !(cur_full_q && nxt_full_q) : !cur_full_q;

    always_comb begin
        keep_mask = '0;
        for (int b = 0; b < KW; b++) keep_mask[b*8 +: 8] = {8{in_keep[b]}};
    end

    always_comb begin
        state_d     = state_q;
        cur_d       = cur_q;
        nxt_d       = nxt_q;
        cur_full_d  = cur_full_q;
        nxt_full_d  = nxt_full_q;
        lane_d      = lane_q;
        ks_req_d    = ks_req_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_keep_d  = out_keep_q;
        out_last_d  = out_last_q;
        blk_cnt_d   = blk_cnt_q;
        if (ks_hit) begin
            blk_cnt_d = blk_cnt_q + 32'd1;
            ks_req_d  = 1'b0;
        end else if (active && !ks_req_q && slot_free && !end_msg) begin
            ks_req_d = 1'b1;
        end
        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = (in_data ^ lane_sel) & keep_mask;
            out_keep_d  = in_keep;
            out_last_d  = in_last;
            lane_d      = (lane_q == LANE_MAX) ? '0 : lane_q + LW'(1);
            if (lane_q == LANE_MAX) begin
                cur_d      = nxt_q;
                cur_full_d = nxt_full_q;
                nxt_full_d = 1'b0;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
        // Capture after the consume so a block arriving with the last-lane beat lands in the freed slot.
        if (ks_hit && active) begin
            if (!cur_full_d) begin
                cur_d      = ks_data;
                cur_full_d = 1'b1;
            end else begin
                nxt_d      = ks_data;
                nxt_full_d = 1'b1;
            end
        end
        case (state_q)
            S_IDLE: if (start) begin
                state_d    = S_FETCH;
                blk_cnt_d  = '0;
                cur_full_d = 1'b0;
                nxt_full_d = 1'b0;
                lane_d     = '0;
                ks_req_d   = 1'b1;
            end
            S_FETCH: state_d = ks_hit ? S_RUN : S_FETCH;
            S_RUN: if (end_msg) begin
                state_d    = ks_req_d ? S_DRAIN : S_IDLE;
                cur_full_d = 1'b0;
                nxt_full_d = 1'b0;
                lane_d     = '0;
            end
            default: state_d = ks_hit ? S_IDLE : S_DRAIN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cur_q       <= '0;
            nxt_q       <= '0;
            cur_full_q  <= 1'b0;
            nxt_full_q  <= 1'b0;
            lane_q      <= '0;
            ks_req_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_keep_q  <= '0;
            out_last_q  <= 1'b0;
            blk_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            cur_q       <= cur_d;
            nxt_q       <= nxt_d;
            cur_full_q  <= cur_full_d;
            nxt_full_q  <= nxt_full_d;
            lane_q      <= lane_d;
            ks_req_q    <= ks_req_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_keep_q  <= out_keep_d;
            out_last_q  <= out_last_d;
            blk_cnt_q   <= blk_cnt_d;
        end
    end

    assign ks_req    = ks_req_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_keep  = out_keep_q;
    assign out_last  = out_last_q;
    assign blk_cnt   = blk_cnt_q;
    assign busy      = state_q != S_IDLE;
endmodule
